// File: rtl/dbi_pkg.sv
// Shared definitions for the DBI master: FSM state encoding and the
// port-logic / config-header register offsets used during bring-up.
package dbi_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_INIT_ACC = 2'd1,
      ST_IDLE     = 2'd2,
      ST_ACC      = 2'd3
   } dbi_state_e;

   localparam logic [31:0] MISC_CONTROL_1_ADDR = 32'h0000_08BC;
   localparam logic [31:0] PORT_LINK_CTRL_ADDR = 32'h0000_0710;
   localparam logic [31:0] STATUS_COMMAND_ADDR = 32'h0000_0004;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/dbi_master.sv
// Single-outstanding DBI master for the RC PCIe core config space. After reset
// it optionally opens RO write protection, then runs one read/write per command.
module dbi_master
   import dbi_pkg::*;
#(
   parameter int unsigned INIT_RO_WR_EN  = 1,
   parameter logic [31:0] MISC_CTRL_ADDR = MISC_CONTROL_1_ADDR,
   parameter logic [31:0] MISC_CTRL_DATA = 32'h0000_0001,
   parameter int unsigned ACK_TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_be,
   input  logic        cmd_cs2,

   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_done,

   input  logic [31:0] drp_lbc_dbi_dout,
   input  logic        drp_lbc_dbi_ack,
   output logic [31:0] drp_dbi_din,
   output logic [3:0]  drp_dbi_wr,
   output logic [31:0] drp_dbi_addr,
   output logic        drp_dbi_cs,
   output logic        drp_dbi_cs2_exp,
   output logic [1:0]  drp_dbi_vfunc_num,
   output logic        drp_dbi_vfunc_active,
   output logic [2:0]  drp_dbi_bar_num,
   output logic        drp_dbi_rom_access,
   output logic        drp_dbi_io_access,
   output logic        drp_dbi_func_num,
   output logic        drp_app_dbi_ro_wr_disable
);

   localparam int          CW      = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   dbi_state_e    state_q, state_d;
   logic          cs_q, cs_d;
   logic          cs2_q, cs2_d;
   logic [3:0]    wr_q, wr_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   din_q, din_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;
   logic          init_done_q, init_done_d;
   logic          ro_dis_q, ro_dis_d;

   // Ready is withheld during the response cycle so a new command never overlaps it.
   assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;

   always_comb begin
      state_d     = state_q;
      cs_d        = cs_q;
      cs2_d       = cs2_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      din_d       = din_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      init_done_d = init_done_q;
      ro_dis_d    = ro_dis_q;

      case (state_q)
         ST_INIT: begin
            if (INIT_RO_WR_EN != 0) begin
               addr_d  = MISC_CTRL_ADDR;
               din_d   = MISC_CTRL_DATA;
               wr_d    = 4'hF;
               cs2_d   = 1'b0;
               cs_d    = 1'b1;
               cnt_d   = '0;
               state_d = ST_INIT_ACC;
            end else begin
               init_done_d = 1'b1;
               ro_dis_d    = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d  = cmd_addr;
               din_d   = cmd_wdata;
               wr_d    = cmd_write ? cmd_be : 4'h0;
               cs2_d   = cmd_cs2;
               cs_d    = 1'b1;
               cnt_d   = '0;
               state_d = ST_ACC;
            end
         end

         ST_INIT_ACC, ST_ACC: begin
            if (drp_lbc_dbi_ack) begin
               cs_d    = 1'b0;
               wr_d    = 4'h0;
               cs2_d   = 1'b0;
               state_d = ST_IDLE;
               if (state_q == ST_ACC) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  if (wr_q == 4'h0) rsp_rdata_d = drp_lbc_dbi_dout;
               end else begin
                  init_done_d = 1'b1;
                  ro_dis_d    = 1'b0;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Abandon the access; protection stays closed if this was the init write.
               cs_d    = 1'b0;
               wr_d    = 4'h0;
               cs2_d   = 1'b0;
               state_d = ST_IDLE;
               if (state_q == ST_ACC) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = TIMEOUT_RDATA;
               end else begin
                  init_done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         cs_q        <= 1'b0;
         cs2_q       <= 1'b0;
         wr_q        <= 4'h0;
         addr_q      <= '0;
         din_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         init_done_q <= 1'b0;
         ro_dis_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         cs_q        <= cs_d;
         cs2_q       <= cs2_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         init_done_q <= init_done_d;
         ro_dis_q    <= ro_dis_d;
      end
   end

   assign rsp_valid                 = rsp_valid_q;
   assign rsp_rdata                 = rsp_rdata_q;
   assign rsp_err                   = rsp_err_q;
   assign init_done                 = init_done_q;
   assign drp_dbi_din               = din_q;
   assign drp_dbi_wr                = wr_q;
   assign drp_dbi_addr              = addr_q;
   assign drp_dbi_cs                = cs_q;
   assign drp_dbi_cs2_exp           = cs2_q;
   assign drp_app_dbi_ro_wr_disable = ro_dis_q;

   assign drp_dbi_vfunc_num    = 2'b00;
   assign drp_dbi_vfunc_active = 1'b0;
   assign drp_dbi_bar_num      = 3'b000;
   assign drp_dbi_rom_access   = 1'b0;
   assign drp_dbi_io_access    = 1'b0;
   assign drp_dbi_func_num     = 1'b0;

endmodule

// File: tb/tb_dbi_master.sv
// Bench for dbi_master: a core-side slave with its own register store, a
// reference register map for expected read data, and a response monitor.
module tb_dbi_master;

   localparam int unsigned TO = 32;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_be;
   logic        cmd_cs2;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_done;
   logic [31:0] dout;
   logic        ack;
   logic [31:0] drp_dbi_din;
   logic [3:0]  drp_dbi_wr;
   logic [31:0] drp_dbi_addr;
   logic        drp_dbi_cs;
   logic        drp_dbi_cs2_exp;
   logic [1:0]  vfunc_num;
   logic        vfunc_active;
   logic [2:0]  bar_num;
   logic        rom_access;
   logic        io_access;
   logic        func_num;
   logic        ro_dis;

   dbi_master #(.ACK_TIMEOUT(TO)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .cmd_valid                 (cmd_valid),
      .cmd_ready                 (cmd_ready),
      .cmd_write                 (cmd_write),
      .cmd_addr                  (cmd_addr),
      .cmd_wdata                 (cmd_wdata),
      .cmd_be                    (cmd_be),
      .cmd_cs2                   (cmd_cs2),
      .rsp_valid                 (rsp_valid),
      .rsp_rdata                 (rsp_rdata),
      .rsp_err                   (rsp_err),
      .init_done                 (init_done),
      .drp_lbc_dbi_dout          (dout),
      .drp_lbc_dbi_ack           (ack),
      .drp_dbi_din               (drp_dbi_din),
      .drp_dbi_wr                (drp_dbi_wr),
      .drp_dbi_addr              (drp_dbi_addr),
      .drp_dbi_cs                (drp_dbi_cs),
      .drp_dbi_cs2_exp           (drp_dbi_cs2_exp),
      .drp_dbi_vfunc_num         (vfunc_num),
      .drp_dbi_vfunc_active      (vfunc_active),
      .drp_dbi_bar_num           (bar_num),
      .drp_dbi_rom_access        (rom_access),
      .drp_dbi_io_access         (io_access),
      .drp_dbi_func_num          (func_num),
      .drp_app_dbi_ro_wr_disable (ro_dis)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // {chk_data, err, rdata}
   logic [33:0] exp_q[$];
   // {cs2, wr, addr, din}
   logic [68:0] acc_q[$];

   logic [31:0] ref_mem [logic [32:0]];
   logic [31:0] sl_mem  [logic [32:0]];

   int   plan_delay = 0;
   bit   plan_to    = 1'b0;
   bit   spur_req   = 1'b0;
   int   rsp_cnt    = 0;

   task automatic chk(input bit ok, input string name, input logic [68:0] act, input logic [68:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] def_val(input logic [32:0] k);
      return {k[15:0], ~k[15:0]} ^ 32'h3C3C_0000;
   endfunction

   function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_read(input logic [32:0] k);
      return ref_mem.exists(k) ? ref_mem[k] : def_val(k);
   endfunction

   // ---------------- core-side slave ----------------
   logic [68:0] cap;
   int          hi_cnt;
   bit          in_acc;
   bit          ack_sent;

   initial begin
      ack = 1'b0; dout = '0; in_acc = 0; ack_sent = 0; hi_cnt = 0; cap = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ack = 1'b0; in_acc = 0; ack_sent = 0; hi_cnt = 0;
         end else if (ack_sent) begin
            ack = 1'b0; ack_sent = 0; in_acc = 0;
            chk(drp_dbi_cs == 1'b0 && drp_dbi_wr == 4'h0 && drp_dbi_cs2_exp == 1'b0, "cs_fall_after_ack",
                {drp_dbi_cs, drp_dbi_wr, drp_dbi_cs2_exp}, 0);
         end else if (in_acc) begin
            if (!drp_dbi_cs) begin
               in_acc = 0;
               chk(plan_to && hi_cnt == int'(TO), "timeout_len", hi_cnt, TO);
            end else begin
               chk({drp_dbi_cs2_exp, drp_dbi_wr, drp_dbi_addr, drp_dbi_din} == cap, "hold_stable",
                   {drp_dbi_cs2_exp, drp_dbi_wr, drp_dbi_addr, drp_dbi_din}, cap);
               hi_cnt++;
               slave_maybe_ack();
            end
         end else if (drp_dbi_cs) begin
            cap = {drp_dbi_cs2_exp, drp_dbi_wr, drp_dbi_addr, drp_dbi_din};
            if (acc_q.size() == 0) begin
               chk(1'b0, "extra_access", cap, 0);
            end else begin
               logic [68:0] e;
               e = acc_q.pop_front();
               chk(cap == e, "access_fields", cap, e);
            end
            in_acc = 1; hi_cnt = 1;
            slave_maybe_ack();
         end else if (spur_req) begin
            ack = 1'b1; dout = $urandom; spur_req = 1'b0;
         end else begin
            ack = 1'b0;
         end
      end
   end

   task automatic slave_maybe_ack();
      logic [32:0] k;
      k = {cap[68], cap[63:32]};
      if (!plan_to && (hi_cnt - 1) == plan_delay) begin
         ack = 1'b1; ack_sent = 1;
         if (cap[67:64] == 4'h0) begin
            dout = sl_mem.exists(k) ? sl_mem[k] : def_val(k);
         end else begin
            dout = $urandom;
            sl_mem[k] = merge_be(sl_mem.exists(k) ? sl_mem[k] : def_val(k), cap[31:0], cap[67:64]);
         end
      end
   endtask

   // ---------------- response monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_rsp", {rsp_err, rsp_rdata}, 0);
            end else begin
               logic [33:0] e;
               e = exp_q.pop_front();
               chk(rsp_err == e[32], "rsp_err", rsp_err, e[32]);
               if (e[33]) chk(rsp_rdata == e[31:0], "rsp_rdata", rsp_rdata, e[31:0]);
               chk(cmd_ready == 1'b0, "ready_low_in_rsp", cmd_ready, 0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = cmd_ready;
      if (!ok) chk(1'b0, "ready_wait_timeout", n, 100);
   endtask

   task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input bit c2, input int dly, input bit to, input bit noise);
      bit          ok;
      bit          eff_wr;
      logic [32:0] k;
      int          n;
      wait_ready(ok);
      if (!ok) return;
      eff_wr = wr && (be != 4'h0);
      k = {c2, a};
      acc_q.push_back({c2, (eff_wr ? be : 4'h0), a, d});
      plan_delay = dly;
      plan_to    = to;
      if (to)          exp_q.push_back({1'b1, 1'b1, 32'hFFFF_FFFF});
      else if (eff_wr) begin
         ref_mem[k] = merge_be(ref_read(k), d, be);
         exp_q.push_back({1'b0, 1'b0, 32'h0});
      end else         exp_q.push_back({1'b1, 1'b0, ref_read(k)});
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_be = be; cmd_cs2 = c2;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk(drp_dbi_cs == 1'b1, "cs_one_cycle_after_accept", drp_dbi_cs, 1);
      chk(cmd_ready == 1'b0, "ready_low_when_busy", cmd_ready, 0);
      n = 0;
      while (!rsp_valid && n < int'(TO) + 20) begin
         cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = $urandom; cmd_wdata = $urandom; cmd_be = 4'($urandom_range(0, 15));
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      if (!rsp_valid) chk(1'b0, "rsp_wait_timeout", n, TO);
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (!init_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(init_done == 1'b1, name, init_done, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      int rc;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_be = 4'h0; cmd_cs2 = 1'b0;
      ref_mem[{1'b0, 32'h710}] = 32'h0001_0120;
      sl_mem[{1'b0, 32'h710}]  = 32'h0001_0120;
      ref_mem[{1'b0, 32'h8BC}] = 32'h0000_0001;
      acc_q.push_back({1'b0, 4'hF, 32'h0000_08BC, 32'h0000_0001});
      plan_delay = 2; plan_to = 1'b0;

      repeat (3) @(negedge clk);
      chk(drp_dbi_cs == 0 && drp_dbi_wr == 0 && drp_dbi_addr == 0 && drp_dbi_din == 0 && drp_dbi_cs2_exp == 0,
          "reset_dbi_outputs", {drp_dbi_cs, drp_dbi_wr, drp_dbi_addr}, 0);
      chk(ro_dis == 1'b1, "reset_ro_wr_disable", ro_dis, 1);
      chk(cmd_ready == 0 && rsp_valid == 0 && rsp_err == 0 && init_done == 0, "reset_ctrl",
          {cmd_ready, rsp_valid, rsp_err, init_done}, 0);
      chk(rsp_rdata == 32'h0, "reset_rdata", rsp_rdata, 0);
      chk({vfunc_num, vfunc_active, bar_num, rom_access, io_access, func_num} == 9'h0, "tied_zero",
          {vfunc_num, vfunc_active, bar_num, rom_access, io_access, func_num}, 0);

      rst = 1'b0;
      @(negedge clk);
      chk(ro_dis == 1'b1 && init_done == 1'b0, "ro_held_during_init", {ro_dis, init_done}, 2'b10);
      wait_init("init_done_set");
      chk(ro_dis == 1'b0, "ro_wr_disable_cleared", ro_dis, 0);
      chk(acc_q.size() == 0, "init_access_seen", acc_q.size(), 0);

      // directed accesses
      issue(1'b0, 32'h0000_0710, 32'h0, 4'h0, 1'b0, 1, 1'b0, 1'b0);
      issue(1'b1, 32'h0000_0004, 32'h0011_0007, 4'hF, 1'b0, 3, 1'b0, 1'b1);
      issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0);
      issue(1'b1, 32'h0000_08BC, 32'hDEAD_BEEF, 4'h0, 1'b0, 2, 1'b0, 1'b0);
      issue(1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 1'b1, 1, 1'b0, 1'b0);
      issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b1, 0, 1'b0, 1'b0);
      issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0);
      issue(1'b0, 32'h0000_0710, 32'h0, 4'h0, 1'b0, 0, 1'b1, 1'b1);
      wait_ready(ok);
      chk(ok, "ready_after_timeout", ok, 1);
      chk(rsp_rdata == 32'hFFFF_FFFF && rsp_err == 1'b1, "timeout_rsp_held", {rsp_err, rsp_rdata},
          {1'b1, 32'hFFFF_FFFF});

      // spurious ack while idle must not produce anything
      rc = rsp_cnt;
      spur_req = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk(drp_dbi_cs == 1'b0, "no_cs_on_spurious_ack", drp_dbi_cs, 0);
      end
      chk(rsp_cnt == rc, "no_rsp_on_spurious_ack", rsp_cnt, rc);
      chk(cmd_ready == 1'b1, "ready_after_spurious_ack", cmd_ready, 1);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0: a = 32'h0000_0004;
            1: a = 32'h0000_0710;
            2: a = 32'h0000_08BC;
            default: a = {20'h0, 10'($urandom), 2'b00};
         endcase
         issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      end

      // reset in the middle of an access
      wait_ready(ok);
      if (ok) begin
         acc_q.push_back({1'b0, 4'h0, 32'h0000_0710, 32'h0});
         plan_to = 1'b1;
         cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h710; cmd_wdata = 32'h0; cmd_be = 4'h0; cmd_cs2 = 1'b0;
         @(posedge clk);
         #1 cmd_valid = 1'b0;
         @(negedge clk);
         chk(drp_dbi_cs == 1'b1, "cs_before_mid_reset", drp_dbi_cs, 1);
         #2 rst = 1'b1;
         #1;
         chk(drp_dbi_cs == 1'b0, "cs_drop_on_async_reset", drp_dbi_cs, 0);
         chk(ro_dis == 1'b1 && init_done == 1'b0 && cmd_ready == 1'b0, "state_on_async_reset",
             {ro_dis, init_done, cmd_ready}, 3'b100);
         @(negedge clk);
         @(negedge clk);
         acc_q.push_back({1'b0, 4'hF, 32'h0000_08BC, 32'h0000_0001});
         sl_mem[{1'b0, 32'h8BC}]  = 32'h0000_0001;
         ref_mem[{1'b0, 32'h8BC}] = 32'h0000_0001;
         plan_to = 1'b0; plan_delay = 1;
         rst = 1'b0;
         wait_init("init_rerun_done");
         chk(ro_dis == 1'b0, "ro_cleared_after_rerun", ro_dis, 0);
         chk(acc_q.size() == 0, "init_rerun_access_seen", acc_q.size(), 0);
      end

      issue(1'b0, 32'h0000_08BC, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk(exp_q.size() == 0, "exp_q_drained", exp_q.size(), 0);
      chk(acc_q.size() == 0, "acc_q_drained", acc_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=%0t required=finish", $time);
      $fatal(1, "global timeout");
   end

endmodule
